// File: rtl/adc_frame_align.sv
// -----------------------------------------------------------------------------
// adc_frame_align
//
// Frame-clock alignment controller for the LVDS ADC receive path. It runs in
// the divided ISERDES clock domain. The deserialised FCO word is compared with
// FRAME_PATTERN. While the word does not match, the controller sends
// single-cycle bitslip pulses to every ISERDES in the clock group. After
// LOCK_COUNT consecutive matches it declares lock. After MISS_LIMIT
// consecutive mismatches in lock it restarts the search. Once MAX_SLIPS slips
// have been used in one attempt, the next mismatch parks the controller in a
// failure state.
//
// Ports
//   CLKDIV      in   divided ISERDES clock (only clock)
//   rst_n       in   asynchronous active-low reset
//   ce          in   enable; low forces IDLE and clears the attempt
//   realign     in   one-cycle request to restart alignment
//   frm_data    in   ISERDES frame word, SER_W bits
//   ch_data_i   in   raw channel samples, channel 0 in the LSBs
//   bitslip     out  bitslip pulse to all ISERDES
//   aligned     out  frame locked (state == LOCKED)
//   align_err   out  slip budget exhausted (state == FAIL)
//   ch_data_o   out  ch_data_i delayed by one cycle
//   data_valid  out  aligned delayed by one cycle
//   slip_total  out  saturating count of slips since reset
//   loss_total  out  saturating count of lock losses since reset
//
// Build option
//   ADC_ALIGN_STATS_EN : when defined, slip_total and loss_total are live
//                        saturating counters. When undefined, both ports are
//                        tied to zero and no counter registers exist.
// -----------------------------------------------------------------------------
module adc_frame_align #(
    parameter int               SER_W         = 8,
    parameter logic [SER_W-1:0] FRAME_PATTERN = SER_W'(8'hF0),
    parameter int               LOCK_COUNT    = 16,
    parameter int               MISS_LIMIT    = 4,
    parameter int               SETTLE_CYC    = 4,
    parameter int               MAX_SLIPS     = 8,
    parameter int               NUM_CH        = 5,
    parameter int               DATA_W        = 16
) (
    input  logic                     CLKDIV,
    input  logic                     rst_n,
    input  logic                     ce,
    input  logic                     realign,
    input  logic [SER_W-1:0]         frm_data,
    input  logic [NUM_CH*DATA_W-1:0] ch_data_i,
    output logic                     bitslip,
    output logic                     aligned,
    output logic                     align_err,
    output logic [NUM_CH*DATA_W-1:0] ch_data_o,
    output logic                     data_valid,
    output logic [15:0]              slip_total,
    output logic [7:0]               loss_total
);

    localparam int MATCH_W  = $clog2(LOCK_COUNT + 1);
    localparam int MISS_W   = $clog2(MISS_LIMIT + 1);
    localparam int SLIP_W   = (MAX_SLIPS < 1) ? 1 : $clog2(MAX_SLIPS + 1);
    localparam int SETTLE_W = $clog2(SETTLE_CYC + 1);

    // Terminal values. Each counter stops at its terminal value and leaves
    // the state before it could wrap.
    localparam logic [MATCH_W-1:0]  MATCH_LAST  = MATCH_W'(LOCK_COUNT - 1);
    localparam logic [MISS_W-1:0]   MISS_LAST   = MISS_W'(MISS_LIMIT - 1);
    localparam logic [SLIP_W-1:0]   SLIP_MAX    = SLIP_W'(MAX_SLIPS);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CHECK  = 3'd1,
        S_SLIP   = 3'd2,
        S_SETTLE = 3'd3,
        S_LOCKED = 3'd4,
        S_FAIL   = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic [MATCH_W-1:0]    match_q, match_d;
    logic [MISS_W-1:0]     miss_q, miss_d;
    logic [SLIP_W-1:0]     slip_q, slip_d;
    logic [SETTLE_W-1:0]   settle_q, settle_d;

    logic                     bitslip_q;
    logic                     aligned_q;
    logic                     align_err_q;
    logic                     data_valid_q;
    logic [NUM_CH*DATA_W-1:0] ch_data_q;

    logic frame_ok_s;

    assign frame_ok_s = (frm_data == FRAME_PATTERN);

    // State and per-attempt counter registers
    always_ff @(posedge CLKDIV or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            match_q  <= {MATCH_W{1'b0}};
            miss_q   <= {MISS_W{1'b0}};
            slip_q   <= {SLIP_W{1'b0}};
            settle_q <= {SETTLE_W{1'b0}};
        end else begin
            state_q  <= state_d;
            match_q  <= match_d;
            miss_q   <= miss_d;
            slip_q   <= slip_d;
            settle_q <= settle_d;
        end
    end

    // Next state and counter update. ce low overrides realign, and realign
    // overrides normal sequencing.
    always_comb begin
        state_d  = state_q;
        match_d  = match_q;
        miss_d   = miss_q;
        slip_d   = slip_q;
        settle_d = settle_q;
        if (!ce) begin
            state_d  = S_IDLE;
            match_d  = {MATCH_W{1'b0}};
            miss_d   = {MISS_W{1'b0}};
            slip_d   = {SLIP_W{1'b0}};
            settle_d = {SETTLE_W{1'b0}};
        end else if (realign) begin
            // A pulse already on the wire this cycle still completes, but the
            // new attempt starts at CHECK and no settle or slip follows it.
            state_d  = S_CHECK;
            match_d  = {MATCH_W{1'b0}};
            miss_d   = {MISS_W{1'b0}};
            slip_d   = {SLIP_W{1'b0}};
            settle_d = {SETTLE_W{1'b0}};
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_CHECK;
                end
                S_CHECK: begin
                    if (frame_ok_s) begin
                        if (match_q == MATCH_LAST) begin
                            state_d = S_LOCKED;
                            match_d = {MATCH_W{1'b0}};
                        end else begin
                            match_d = match_q + MATCH_W'(1'b1);
                        end
                    end else begin
                        match_d = {MATCH_W{1'b0}};
                        if (slip_q == SLIP_MAX) begin
                            state_d = S_FAIL;
                        end else begin
                            state_d = S_SLIP;
                        end
                    end
                end
                S_SLIP: begin
                    // slip_q is below SLIP_MAX here, because CHECK only
                    // enters SLIP while the budget is not used up.
                    slip_d   = slip_q + SLIP_W'(1'b1);
                    settle_d = {SETTLE_W{1'b0}};
                    state_d  = S_SETTLE;
                end
                S_SETTLE: begin
                    if (settle_q == SETTLE_LAST) begin
                        settle_d = {SETTLE_W{1'b0}};
                        state_d  = S_CHECK;
                    end else begin
                        settle_d = settle_q + SETTLE_W'(1'b1);
                    end
                end
                S_LOCKED: begin
                    if (frame_ok_s) begin
                        miss_d = {MISS_W{1'b0}};
                    end else if (miss_q == MISS_LAST) begin
                        state_d = S_CHECK;
                        match_d = {MATCH_W{1'b0}};
                        miss_d  = {MISS_W{1'b0}};
                        slip_d  = {SLIP_W{1'b0}};
                    end else begin
                        miss_d = miss_q + MISS_W'(1'b1);
                    end
                end
                S_FAIL: begin
                    state_d = S_FAIL;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Output registers. The status bits decode the next state, so each one
    // exactly matches the current state. Samples are captured unconditionally.
    always_ff @(posedge CLKDIV or negedge rst_n) begin
        if (!rst_n) begin
            bitslip_q    <= 1'b0;
            aligned_q    <= 1'b0;
            align_err_q  <= 1'b0;
            data_valid_q <= 1'b0;
            ch_data_q    <= {(NUM_CH*DATA_W){1'b0}};
        end else begin
            bitslip_q    <= (state_d == S_SLIP);
            aligned_q    <= (state_d == S_LOCKED);
            align_err_q  <= (state_d == S_FAIL);
            data_valid_q <= aligned_q;
            ch_data_q    <= ch_data_i;
        end
    end

    assign bitslip    = bitslip_q;
    assign aligned    = aligned_q;
    assign align_err  = align_err_q;
    assign data_valid = data_valid_q;
    assign ch_data_o  = ch_data_q;

`ifdef ADC_ALIGN_STATS_EN
    logic [15:0] slip_total_q;
    logic [7:0]  loss_total_q;
    logic        loss_event_s;

    // A lock loss is the MISS_LIMIT-th consecutive mismatch in LOCKED, and
    // only counts when ce and realign leave normal sequencing in control.
    assign loss_event_s = ce && !realign && (state_q == S_LOCKED) &&
                          !frame_ok_s && (miss_q == MISS_LAST);

    // Saturating statistics counters, cleared only by rst_n
    always_ff @(posedge CLKDIV or negedge rst_n) begin
        if (!rst_n) begin
            slip_total_q <= 16'h0000;
            loss_total_q <= 8'h00;
        end else begin
            if ((state_q == S_SLIP) && (slip_total_q != 16'hFFFF)) begin
                slip_total_q <= slip_total_q + 16'd1;
            end
            if (loss_event_s && (loss_total_q != 8'hFF)) begin
                loss_total_q <= loss_total_q + 8'd1;
            end
        end
    end

    assign slip_total = slip_total_q;
    assign loss_total = loss_total_q;
`else
    assign slip_total = 16'h0000;
    assign loss_total = 8'h00;
`endif

endmodule

// File: tb/tb_adc_frame_align.sv
// -----------------------------------------------------------------------------
// tb_adc_frame_align
//
// Directed bench for adc_frame_align with default parameters. A behavioural
// model describes the search as "mode + blanking window". It predicts every
// output each cycle, and a single process compares the DUT against the
// prediction on the falling edge. Hand-computed literal checks pin the slip
// count, the slip spacing, the lock latency and the lock-loss and gating
// behaviour.
// -----------------------------------------------------------------------------
module tb_adc_frame_align;

    localparam int          NUM_CH     = 5;
    localparam int          DATA_W     = 16;
    localparam int          BW         = NUM_CH * DATA_W;
    localparam logic [7:0]  PAT        = 8'hF0;
    localparam int          LOCK_COUNT = 16;
    localparam int          MISS_LIMIT = 4;
    localparam int          SETTLE_CYC = 4;
    localparam int          MAX_SLIPS  = 8;
`ifdef ADC_ALIGN_STATS_EN
    localparam int          STATS      = 1;
`else
    localparam int          STATS      = 0;
`endif

    localparam int MODE_IDLE   = 0;
    localparam int MODE_SEARCH = 1;
    localparam int MODE_LOCKED = 2;
    localparam int MODE_FAILED = 3;

    logic          CLKDIV = 1'b0;
    logic          rst_n  = 1'b0;
    logic          ce     = 1'b0;
    logic          realign = 1'b0;
    logic [7:0]    frm_data = 8'h00;
    logic [BW-1:0] ch_data_i = '0;
    logic          bitslip, aligned, align_err, data_valid;
    logic [BW-1:0] ch_data_o;
    logic [15:0]   slip_total;
    logic [7:0]    loss_total;

    adc_frame_align dut (
        .CLKDIV     (CLKDIV),
        .rst_n      (rst_n),
        .ce         (ce),
        .realign    (realign),
        .frm_data   (frm_data),
        .ch_data_i  (ch_data_i),
        .bitslip    (bitslip),
        .aligned    (aligned),
        .align_err  (align_err),
        .ch_data_o  (ch_data_o),
        .data_valid (data_valid),
        .slip_total (slip_total),
        .loss_total (loss_total)
    );

    initial begin
        forever #5 CLKDIV = ~CLKDIV;
    end

    // ---------------- behavioural model ----------------
    int            m_mode, m_good, m_bad, m_slips, m_blank;
    int            m_slip_tot, m_loss_tot;
    logic          e_bitslip, e_aligned, e_err, e_valid;
    logic [BW-1:0] e_data;

    task automatic model_reset();
        m_mode = MODE_IDLE; m_good = 0; m_bad = 0; m_slips = 0; m_blank = 0;
        m_slip_tot = 0; m_loss_tot = 0;
        e_bitslip = 1'b0; e_aligned = 1'b0; e_err = 1'b0; e_valid = 1'b0;
        e_data = '0;
    endtask

    task automatic model_clear_attempt();
        m_good = 0; m_bad = 0; m_slips = 0; m_blank = 0;
    endtask

    task automatic model_step();
        logic slip_now;
        slip_now = 1'b0;
        // Every pulse shown during the ending cycle is one slip.
        if (e_bitslip && (m_slip_tot < 65535)) m_slip_tot++;
        e_valid = e_aligned;
        e_data  = ch_data_i;
        if (!ce) begin
            m_mode = MODE_IDLE;
            model_clear_attempt();
        end else if (realign) begin
            m_mode = MODE_SEARCH;
            model_clear_attempt();
        end else begin
            case (m_mode)
                MODE_IDLE: m_mode = MODE_SEARCH;
                MODE_SEARCH: begin
                    if (m_blank > 0) begin
                        m_blank--;
                    end else if (frm_data == PAT) begin
                        m_good++;
                        if (m_good == LOCK_COUNT) begin
                            m_mode = MODE_LOCKED; m_good = 0; m_bad = 0;
                        end
                    end else begin
                        m_good = 0;
                        if (m_slips == MAX_SLIPS) begin
                            m_mode = MODE_FAILED;
                        end else begin
                            m_slips++;
                            slip_now = 1'b1;
                            m_blank  = 1 + SETTLE_CYC;  // pulse cycle + settle window
                        end
                    end
                end
                MODE_LOCKED: begin
                    if (frm_data != PAT) begin
                        m_bad++;
                        if (m_bad == MISS_LIMIT) begin
                            m_mode = MODE_SEARCH;
                            model_clear_attempt();
                            if (m_loss_tot < 255) m_loss_tot++;
                        end
                    end else begin
                        m_bad = 0;
                    end
                end
                default: ;  // failed: held
            endcase
        end
        e_bitslip = slip_now;
        e_aligned = (m_mode == MODE_LOCKED);
        e_err     = (m_mode == MODE_FAILED);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge CLKDIV or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    // ---------------- checking / stimulus ----------------
    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int pulses = 0;
    int pulse_cyc[$];
    int rot = 0;
    logic use_rot = 1'b0;
    logic [7:0] fixed_frm = 8'h00;
    int lock_cyc = 0;

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        logic [7:0] r;
        r = v;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic drive_frame();
        frm_data = use_rot ? rotl(PAT, rot) : fixed_frm;
    endtask

    // One clock: let the edge happen, compare on the falling edge, then drive.
    task automatic step();
        @(posedge CLKDIV);
        @(negedge CLKDIV);
        cyc++;
        chk("bitslip",    BW'(bitslip),    BW'(e_bitslip));
        chk("aligned",    BW'(aligned),    BW'(e_aligned));
        chk("align_err",  BW'(align_err),  BW'(e_err));
        chk("data_valid", BW'(data_valid), BW'(e_valid));
        chk("ch_data_o",  ch_data_o,       e_data);
        chk("slip_total", BW'(slip_total), BW'(STATS * m_slip_tot));
        chk("loss_total", BW'(loss_total), BW'(STATS * m_loss_tot));
        if (bitslip) begin
            pulses++;
            pulse_cyc.push_back(cyc);
            if (use_rot) rot = (rot + 1) % 8;
        end
        drive_frame();
        for (int c = 0; c < NUM_CH; c++)
            ch_data_i[c*DATA_W +: DATA_W] = 16'(cyc * 7 + c * 1000);
    endtask

    task automatic start_count();
        pulses = 0;
        pulse_cyc.delete();
    endtask

    task automatic wait_aligned(input string name, input int budget);
        int n;
        n = 0;
        while (!aligned && n < budget) begin
            step();
            n++;
        end
        chk(name, BW'(aligned), BW'(1));
        lock_cyc = cyc;
    endtask

    initial begin
        // Reset, then idle with ce low.
        repeat (3) step();
        rst_n = 1'b1;
        repeat (2) step();
        chk("idle_aligned", BW'(aligned), BW'(0));
        chk("idle_bitslip", BW'(bitslip), BW'(0));

        // Offset 3: the word is rot=5 and becomes the pattern after 3 slips.
        use_rot = 1'b1; rot = 5; drive_frame();
        ce = 1'b1;
        start_count();
        wait_aligned("ofs_lock", 200);
        chk("ofs_pulses", BW'(pulses), BW'(3));
        if (pulse_cyc.size() >= 3) begin
            chk("ofs_gap1",    BW'(pulse_cyc[1] - pulse_cyc[0]), BW'(6));
            chk("ofs_gap2",    BW'(pulse_cyc[2] - pulse_cyc[1]), BW'(6));
            // last pulse P, settle P+1..P+4, 16 good samples P+5..P+20
            chk("ofs_latency", BW'(lock_cyc - pulse_cyc[2]), BW'(21));
        end
        chk("ofs_slip_total", BW'(slip_total), BW'(STATS * 3));
        chk("ofs_valid_pre", BW'(data_valid), BW'(0));
        step();
        chk("ofs_valid_rise", BW'(data_valid), BW'(1));

        // Lock loss: 3 misses then a match keeps lock.
        use_rot = 1'b0; fixed_frm = 8'h00; drive_frame();
        repeat (3) step();
        fixed_frm = PAT; drive_frame();
        step();
        chk("miss3_hold", BW'(aligned), BW'(1));
        // 4 consecutive misses drop lock.
        fixed_frm = 8'h00; drive_frame();
        repeat (3) step();
        chk("miss3_still", BW'(aligned), BW'(1));
        step();
        chk("loss_drop", BW'(aligned), BW'(0));
        chk("loss_total", BW'(loss_total), BW'(STATS * 1));
        fixed_frm = PAT; drive_frame();
        step();
        chk("loss_valid_fall", BW'(data_valid), BW'(0));
        wait_aligned("relock", 60);

        // No match: 8 slips, then failure.
        fixed_frm = 8'hAA; drive_frame();
        start_count();
        begin
            int n;
            n = 0;
            while (!align_err && n < 300) begin
                step();
                n++;
            end
        end
        chk("nm_err",     BW'(align_err), BW'(1));
        chk("nm_pulses",  BW'(pulses),    BW'(8));
        chk("nm_aligned", BW'(aligned),   BW'(0));
        repeat (3) step();
        chk("nm_err_held", BW'(align_err), BW'(1));
        realign = 1'b1;
        step();
        realign = 1'b0;
        start_count();
        begin
            int n;
            n = 0;
            while (pulses == 0 && n < 4) begin
                step();
                n++;
            end
        end
        chk("realign_resume", BW'(pulses), BW'(1));
        chk("realign_err_clr", BW'(align_err), BW'(0));

        // ce dropped during SETTLE
        step();
        ce = 1'b0;
        start_count();
        repeat (10) step();
        chk("ce_no_slip", BW'(pulses), BW'(0));
        // Reenable: a fresh attempt needs exactly 3 slips again.
        use_rot = 1'b1; rot = 5; drive_frame();
        ce = 1'b1;
        start_count();
        wait_aligned("ce_relock", 200);
        chk("ce_pulses", BW'(pulses), BW'(3));
        step();

        // ce low while locked: aligned falls, valid follows one cycle later.
        ce = 1'b0;
        step();
        chk("ce_drop_aligned", BW'(aligned), BW'(0));
        chk("ce_drop_valid",   BW'(data_valid), BW'(1));
        step();
        chk("ce_drop_valid2",  BW'(data_valid), BW'(0));

        // Reset in the middle of a search.
        use_rot = 1'b0; fixed_frm = 8'hAA; drive_frame();
        ce = 1'b1;
        repeat (12) step();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_bitslip",    BW'(bitslip),    BW'(0));
        chk("rst_aligned",    BW'(aligned),    BW'(0));
        chk("rst_align_err",  BW'(align_err),  BW'(0));
        chk("rst_valid",      BW'(data_valid), BW'(0));
        chk("rst_ch_data",    ch_data_o,       BW'(0));
        chk("rst_slip_total", BW'(slip_total), BW'(0));
        chk("rst_loss_total", BW'(loss_total), BW'(0));
        repeat (2) step();
        ce = 1'b0;
        rst_n = 1'b1;
        repeat (3) step();
        chk("post_rst_bitslip", BW'(bitslip), BW'(0));
        chk("post_rst_aligned", BW'(aligned), BW'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/adc_frame_align.md
# adc_frame_align

Parametrised frame-clock alignment controller for the LVDS ADC receive path. It runs in the divided ISERDES clock domain and compares the deserialised FCO word against a programmable frame pattern. It issues single-cycle bitslip pulses to every ISERDES that shares the clock group, and declares lock after a run of consecutive matches. It also gates an NUM_CH-channel sample bus with a valid flag, and adds lock-loss detection, a slip-limit failure state and software re-alignment.

## Interface
- SER_W, 8: deserialised frame word width (4..14)
- FRAME_PATTERN, 8'hF0: expected frame word once aligned, SER_W bits
- LOCK_COUNT, 16: consecutive matches required to lock (>=1)
- MISS_LIMIT, 4: consecutive mismatches in lock that cause loss (>=1)
- SETTLE_CYC, 4: wait cycles after each bitslip before re-checking (>=1)
- MAX_SLIPS, 8: slips allowed per attempt before failure
- NUM_CH, 5: sample channels gated
- DATA_W, 16: bits per channel

Ports:
- CLKDIV  in  1: divided ISERDES clock, only clock
- rst_n  in  1: reset, asynchronous, active-low
- ce  in  1: enable; low forces IDLE
- realign  in  1: one-cycle request to restart alignment
- frm_data  in  SER_W: ISERDES frame word
- ch_data_i  in  NUM_CH*DATA_W: raw channel samples, channel 0 in LSBs
- bitslip  out  1: bitslip pulse to all ISERDES
- aligned  out  1: frame locked
- align_err  out  1: slip limit exhausted
- ch_data_o  out  NUM_CH*DATA_W: registered samples
- data_valid  out  1: ch_data_o qualified by lock
- slip_total  out  16: slips since reset (stats)
- loss_total  out  8: lock losses since reset (stats)

## Operation
- States: IDLE, CHECK, SLIP, SETTLE, LOCKED, FAIL. Reset state is IDLE, and all outputs reset to 0.
- ce low in any state: next state is IDLE, bitslip=0, and per-attempt counters (match_cnt, miss_cnt, slip_cnt, settle_cnt) clear. This has priority over realign.
- IDLE → CHECK when ce=1.
- CHECK, frm_data==FRAME_PATTERN:
  - match_cnt increments.
  - On the LOCK_COUNT-th consecutive match → LOCKED.
- CHECK, mismatch:
  - match_cnt clears.
  - If slip_cnt==MAX_SLIPS → FAIL; otherwise → SLIP.
- SLIP: bitslip=1 for exactly this cycle, slip_cnt increments, slip_total increments → SETTLE.
- SETTLE: counts SETTLE_CYC cycles, frm_data ignored → CHECK.
- LOCKED:
  - A mismatch increments miss_cnt; a match clears it.
  - On the MISS_LIMIT-th consecutive mismatch → CHECK, with slip_cnt, match_cnt and miss_cnt cleared, and loss_total incremented.
- FAIL: held until realign or ce low.
- realign=1 (ce=1) in any state → CHECK, with all per-attempt counters cleared. A SLIP in progress still completes its pulse, but no further slip follows it.
- slip_total and loss_total saturate at all-ones. They are cleared only by rst_n.
- Counter widths: $clog2(max+1) of the relevant parameter. No wrap-around is permitted.

## Timing
- aligned and align_err are registered state decodes:
  - aligned=1 exactly while state==LOCKED.
  - align_err=1 exactly while state==FAIL.
- Lock latency: on the cycle after the LOCK_COUNT-th matching sample, aligned goes high.
- Slip cadence during a search: bitslip pulses are spaced 1+SETTLE_CYC+1 cycles apart (SLIP, SETTLE×SETTLE_CYC, one CHECK).
- ch_data_o = ch_data_i delayed by one cycle, captured unconditionally.
- data_valid = aligned delayed by one cycle, so valid is coincident with the samples that were captured while locked.
- bitslip is never high for two consecutive cycles.

## Configuration
- ADC_ALIGN_STATS_EN defined: slip_total and loss_total are live saturating counters.
- ADC_ALIGN_STATS_EN undefined:
  - Both ports remain present and tie to 0.
  - No counter registers are synthesised.
  - All alignment behaviour is unchanged.

## Test plan
All scenarios use default parameters.
- Reset: assert rst_n=0 mid-search → all outputs 0 immediately. After release, state IDLE with ce=0.
- Offset 3: the frm_data model rotates on each bitslip and starts 3 slips away from 8'hF0.
  - Exactly 3 bitslip pulses occur, 6 cycles apart.
  - aligned rises 16 cycles after the first good CHECK sample.
  - slip_total=3.
- No match: frm_data fixed at 8'hAA.
  - 8 bitslip pulses occur, then align_err=1, aligned=0.
  - realign → slips resume.
- Lock loss in LOCKED:
  - 3 mismatches then a match → aligned stays 1.
  - 4 consecutive mismatches → aligned=0 on the next cycle, loss_total=1, search restarts.
- ce dropped during SETTLE → IDLE next cycle, no further bitslip. Raising ce restarts from CHECK with slip_cnt=0.
- Data gating: ramp ch_data_i.
  - ch_data_o lags the input by 1 cycle.
  - data_valid rises 1 cycle after aligned and falls 1 cycle after aligned drops.
